// File: rtl/avalon_pio_out_multi.sv
// avalon_pio_out_multi: NCHAN x WIDTH Avalon-MM output PIO with one-shot pulses.
// Define PIO_PULSE_IRQ_EN for per-channel DONE/IRQ_MASK flags and the irq line.
module avalon_pio_out_multi #(
  parameter int NCHAN  = 4,
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = $clog2(NCHAN) + 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic [WIDTH*NCHAN-1:0] out_port,
  output logic                   irq
);

  logic [31:0]      addr32;
  logic [29:0]      chan;
  logic [1:0]       rsel;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [CNT_W-1:0] wlen;

  assign addr32 = 32'(address);
  assign chan   = addr32[31:2];
  assign rsel   = addr32[1:0];
  assign wr     = chipselect & ~write_n;
  assign wd     = writedata[WIDTH-1:0];
  assign wlen   = writedata[16 +: CNT_W];

  logic [WIDTH-1:0] data_q [NCHAN];
  logic [WIDTH-1:0] data_d [NCHAN];
  logic [WIDTH-1:0] nd     [NCHAN];
  logic [CNT_W-1:0] cnt_q  [NCHAN];
  logic [CNT_W-1:0] cnt_d  [NCHAN];
  logic [CNT_W-1:0] len_q  [NCHAN];
  logic [CNT_W-1:0] len_d  [NCHAN];
  logic [NCHAN-1:0] pen_q;
  logic [NCHAN-1:0] pen_d;
  logic [NCHAN-1:0] hit;
  logic [NCHAN-1:0] expire;
  logic [NCHAN-1:0] done_q;
  logic [NCHAN-1:0] mask_q;

  function automatic logic [CNT_W-1:0] load_len(
    input logic [CNT_W-1:0] l
  );
    return (l == '0) ? CNT_W'(1) : l;
  endfunction

  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      hit[c] = wr && (chan == 30'(c));
      case (rsel)
        2'd1:    nd[c] = data_q[c] | wd;
        2'd2:    nd[c] = data_q[c] & ~wd;
        default: nd[c] = wd;
      endcase
    end
  end

  // A data write always beats expiry; clearing PULSE_EN suppresses it.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      data_d[c] = data_q[c];
      cnt_d[c]  = cnt_q[c];
      len_d[c]  = len_q[c];
      pen_d[c]  = pen_q[c];
      expire[c] = 1'b0;
      if (hit[c] && rsel != 2'd3) begin
        data_d[c] = nd[c];
        cnt_d[c]  = (pen_q[c] && nd[c] != '0) ?
                    load_len(len_q[c]) : '0;
      end else begin
        if (cnt_q[c] == CNT_W'(1)) begin
          data_d[c] = '0;
          cnt_d[c]  = '0;
          expire[c] = 1'b1;
        end else if (cnt_q[c] != '0) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
        if (hit[c]) begin
          pen_d[c] = writedata[0];
          len_d[c] = wlen;
          if (!writedata[0]) begin
            data_d[c] = data_q[c];
            cnt_d[c]  = '0;
            expire[c] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCHAN; c++) begin
        data_q[c] <= '0;
        cnt_q[c]  <= '0;
        len_q[c]  <= '0;
      end
      pen_q <= '0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        data_q[c] <= data_d[c];
        cnt_q[c]  <= cnt_d[c];
        len_q[c]  <= len_d[c];
      end
      pen_q <= pen_d;
    end
  end

`ifdef PIO_PULSE_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      irq_q <= |(done_q & mask_q);
      for (int c = 0; c < NCHAN; c++) begin
        if (hit[c] && rsel == 2'd3) begin
          mask_q[c] <= writedata[2];
          done_q[c] <= expire[c] | (done_q[c] & ~writedata[3]);
        end else begin
          done_q[c] <= expire[c] | done_q[c];
        end
      end
    end
  end

  assign irq = irq_q;

  logic unused_bits;
  assign unused_bits = ^writedata;
`else
  assign done_q = '0;
  assign mask_q = '0;
  assign irq    = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{writedata, expire};
`endif

  always_comb begin
    readdata = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (chan == 30'(c)) begin
        if (rsel == 2'd3) begin
          readdata[0]           = pen_q[c];
          readdata[1]           = (cnt_q[c] != '0);
          readdata[2]           = mask_q[c];
          readdata[3]           = done_q[c];
          readdata[16 +: CNT_W] = len_q[c];
        end else begin
          readdata[WIDTH-1:0] = data_q[c];
        end
      end
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_out
    assign out_port[g*WIDTH +: WIDTH] = data_q[g];
  end

endmodule

// File: tb/tb_avalon_pio_out_multi.sv
// Randomized bench for avalon_pio_out_multi against a timestamp-based model.
// Two instances: NCHAN=4 (default) and NCHAN=3 for out-of-range channel access.
module tb_avalon_pio_out_multi;

`ifdef PIO_PULSE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd4, rd3;
  logic [31:0] out4;
  logic [23:0] out3;
  logic        irq4, irq3;

  always #5 clk = ~clk;

  avalon_pio_out_multi u4 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd4),
    .out_port(out4), .irq(irq4)
  );

  avalon_pio_out_multi #(.NCHAN(3)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd3),
    .out_port(out3), .irq(irq3)
  );

  int npass = 0;
  int ntotal = 0;

  logic [7:0] mdata [2][4];
  bit         mpen  [2][4];
  bit         mmask [2][4];
  bit         mdone [2][4];
  int         mlen  [2][4];
  longint     mend  [2][4];
  bit         mirq  [2];
  longint     now = 0;
  logic [31:0] rl4, rl3;

  function automatic int nch(input int m);
    return (m == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mirq[m] = 0;
      for (int c = 0; c < 4; c++) begin
        mdata[m][c] = '0; mpen[m][c] = 0; mmask[m][c] = 0;
        mdone[m][c] = 0; mlen[m][c] = 0; mend[m][c] = 0;
      end
    end
  endtask

  function automatic logic [31:0] model_out(input int m);
    logic [31:0] r = '0;
    for (int c = 0; c < nch(m); c++) r |= 32'(mdata[m][c]) << (8 * c);
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input int m, input logic [3:0] a);
    int c = int'(a) / 4;
    int r = int'(a) % 4;
    logic [31:0] v;
    if (c >= nch(m)) return '0;
    if (r != 3) return 32'(mdata[m][c]);
    v = 32'(mlen[m][c]) << 16;
    v[3] = mdone[m][c];
    v[2] = mmask[m][c];
    v[1] = (mend[m][c] != 0);
    v[0] = mpen[m][c];
    return v;
  endfunction

  // Pulses are tracked as the absolute edge number at which data must clear.
  task automatic model_step(input logic [3:0] a, input bit wrv,
                            input logic [31:0] d);
    int cs = int'(a) / 4;
    int r  = int'(a) % 4;
    now++;
    for (int m = 0; m < 2; m++) begin
      bit any = 0;
      for (int c = 0; c < nch(m); c++) any |= mdone[m][c] & mmask[m][c];
      mirq[m] = IRQ & any;
      for (int c = 0; c < nch(m); c++) begin
        bit hit = wrv && (cs == c);
        bit dw = hit && (r != 3);
        bit cw = hit && (r == 3);
        bit ex = 0;
        logic [7:0] nv;
        if (dw) begin
          if (r == 0) nv = d[7:0];
          else if (r == 1) nv = mdata[m][c] | d[7:0];
          else nv = mdata[m][c] & ~d[7:0];
          mdata[m][c] = nv;
          mend[m][c] = (mpen[m][c] && nv != 0) ?
                       now + ((mlen[m][c] == 0) ? 1 : mlen[m][c]) : 0;
        end else begin
          ex = (mend[m][c] == now) && (mend[m][c] != 0) && !(cw && !d[0]);
          if (ex) begin mdata[m][c] = '0; mend[m][c] = 0; end
          if (cw && !d[0]) mend[m][c] = 0;
        end
        if (cw) begin
          mpen[m][c] = d[0];
          mlen[m][c] = int'(d[31:16]);
          mmask[m][c] = IRQ & d[2];
        end
        mdone[m][c] = IRQ & (ex | (mdone[m][c] & !(cw && d[3])));
      end
    end
  endtask

  task automatic check_all();
    chk("out4", out4, model_out(0));
    chk("out3", {8'h0, out3}, model_out(1));
    chk("irq4", {31'h0, irq4}, {31'h0, mirq[0]});
    chk("irq3", {31'h0, irq3}, {31'h0, mirq[1]});
    chk("rd4", rd4, model_rd(0, address));
    chk("rd3", rd3, model_rd(1, address));
  endtask

  task automatic cyc(input logic [3:0] a, input bit cs, input bit wn,
                     input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = cs; write_n = wn; writedata = d;
    #1;
    check_all();
    rl4 = rd4; rl3 = rd3;
    @(posedge clk);
    model_step(a, cs && !wn, d);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d);
    #2;
  endtask

  task automatic count_pulse(input int lsb, input logic [3:0] ra,
                             output int n, output bit busy0);
    n = 0;
    busy0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (((out4 >> lsb) & 32'hFF) != 0) n++;
      cyc(ra, 1'b1, 1'b1, 32'h0);
      if (i == 0) busy0 = rl4[1];
      #2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit b;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out4", out4, 32'h0);
    chk("rst_irq4", {31'h0, irq4}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      cyc(4'(a), 1'b1, 1'b1, 32'h0);
      chk("rst_rd", rl4 | rl3, 32'h0);
    end

    wr(4'd4, 32'h0000_00A5);
    chk("data_a5", (out4 >> 8) & 32'hFF, 32'hA5);
    wr(4'd5, 32'h0000_000F);
    chk("set_af", (out4 >> 8) & 32'hFF, 32'hAF);
    wr(4'd6, 32'h0000_0081);
    chk("clr_2e", (out4 >> 8) & 32'hFF, 32'h2E);
    chk("other_ch", out4 & 32'hFFFF_00FF, 32'h0);

    wr(4'd3, 32'h0003_0001);
    wr(4'd0, 32'h0000_0001);
    count_pulse(0, 4'd3, n, b);
    chk("pulse_len3", 32'(n), 32'd3);
    chk("busy_during", {31'h0, b}, 32'h1);
    chk("busy_after", {31'h0, rl4[1]}, 32'h0);
    wr(4'd3, 32'h0000_0001);
    wr(4'd0, 32'h0000_0001);
    count_pulse(0, 4'd3, n, b);
    chk("pulse_len0", 32'(n), 32'd1);

    wr(4'd11, 32'h0005_0001);
    wr(4'd8, 32'h0000_0001);
    cyc(4'd0, 1'b0, 1'b1, 32'h0);
    cyc(4'd0, 1'b0, 1'b1, 32'h0);
    wr(4'd8, 32'h0000_0002);
    count_pulse(16, 4'd11, n, b);
    chk("pulse_rewrite", 32'(n), 32'd5);
    wr(4'd8, 32'h0000_0007);
    cyc(4'd0, 1'b0, 1'b1, 32'h0);
    wr(4'd10, 32'h0000_00FF);
    chk("clr_mid", (out4 >> 16) & 32'hFF, 32'h0);
    cyc(4'd11, 1'b1, 1'b1, 32'h0);
    chk("clr_busy", {31'h0, rl4[1]}, 32'h0);

    wr(4'd15, 32'h0002_0005);
    wr(4'd12, 32'h0000_0080);
    cyc(4'd0, 1'b0, 1'b1, 32'h0);
    cyc(4'd0, 1'b0, 1'b1, 32'h0);
    cyc(4'd15, 1'b1, 1'b1, 32'h0);
    #2;
`ifdef PIO_PULSE_IRQ_EN
    chk("done_set", {31'h0, rl4[3]}, 32'h1);
    chk("irq_set", {31'h0, irq4}, 32'h1);
`else
    chk("done_set", {31'h0, rl4[3]}, 32'h0);
    chk("irq_set", {31'h0, irq4}, 32'h0);
`endif
    wr(4'd15, 32'h0002_000D);
    cyc(4'd0, 1'b0, 1'b1, 32'h0);
    #2;
    chk("irq_clr", {31'h0, irq4}, 32'h0);

    wr(4'd3, 32'h0005_0001);
    wr(4'd0, 32'h0000_000F);
    cyc(4'd0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_out", out4, 32'h0);
    chk("rst_mid_irq", {31'h0, irq4}, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    wr(4'd12, 32'h0000_00FF);
    chk("oor_out3", {8'h0, out3}, 32'h0);
    chk("in_range_out4", out4 >> 24, 32'hFF);
    cyc(4'd12, 1'b1, 1'b1, 32'h0);
    chk("oor_rd3", rl3, 32'h0);
    chk("in_range_rd4", rl4, 32'hFF);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      logic [31:0] d;
      a = 4'($urandom_range(0, 15));
      if (a[1:0] == 2'd3) begin
        d = {16'($urandom_range(0, 6)), 12'h0, 4'($urandom)};
        d[0] = ($urandom_range(0, 3) != 0);
      end else begin
        d = $urandom;
      end
      cyc(a, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, d);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
